// File: rtl/comb_resp_checker.sv
// comb_resp_checker: response-side checker for the 4-input combinational-function
// setup. It samples the implementation outputs on in_valid and checks that they
// agree. It counts vectors and mismatches and logs the first failing vector.
// When COMB_CHK_MISR_EN is defined, it also compacts the responses into a
// 16-bit MISR signature. Without the macro, signature reads 16'h0000.
module comb_resp_checker #(
    parameter int          WIDTH    = 4,
    parameter int          NVEC     = 16,
    parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_vec,
    input  logic [WIDTH-1:0] in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       vec_cnt,
    output logic [4:0]       err_cnt,
    output logic [3:0]       first_err_vec,
    output logic             err_seen,
    output logic [15:0]      signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic accept;
    logic last_sample;
    logic mismatch;

    // A sample counts only while running; start on the same edge wins.
    assign accept      = in_valid && (state_q == RUN);
    assign last_sample = accept && (vec_cnt == 5'(NVEC - 1));
    // All implementations agree when the output bus is all-0 or all-1.
    assign mismatch    = (in_y != '0) && (in_y != '1);

    // Hold the FSM state; reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Choose the next state; start restarts the run from any state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (last_sample) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign pass = done && (err_cnt == 5'd0);

    // Update the vector and mismatch counters and log the first failing vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt       <= 5'd0;
            err_cnt       <= 5'd0;
            first_err_vec <= 4'd0;
            err_seen      <= 1'b0;
        end else if (start) begin
            vec_cnt       <= 5'd0;
            err_cnt       <= 5'd0;
            first_err_vec <= 4'd0;
            err_seen      <= 1'b0;
        end else if (accept) begin
            vec_cnt <= vec_cnt + 5'd1;
            if (mismatch) begin
                err_cnt <= err_cnt + 5'd1;
                if (!err_seen) begin
                    first_err_vec <= in_vec;
                    err_seen      <= 1'b1;
                end
            end
        end
    end

`ifdef COMB_CHK_MISR_EN
    logic [15:0] sig_q;

    // One MISR step: shift left, fold in the CCITT polynomial on carry-out,
    // then XOR in the response bits.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [WIDTH-1:0] y);
        logic [15:0] nxt;
        nxt = {sig[14:0], 1'b0};
        if (sig[15]) nxt = nxt ^ 16'h1021;
        return nxt ^ 16'(y);
    endfunction

    // Compact each accepted response into the signature.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sig_q <= SIG_SEED;
        else if (start)  sig_q <= SIG_SEED;
        else if (accept) sig_q <= misr_step(sig_q, in_y);
    end

    assign signature = sig_q;
`else
    // No MISR is built. The seed has no meaning here, so the output is forced to zero.
    assign signature = SIG_SEED & 16'h0000;
`endif

endmodule

// File: tb/tb_comb_resp_checker.sv
// Directed testbench for comb_resp_checker. The expected signature values follow
// COMB_CHK_MISR_EN, so the same bench serves both builds.
module tb_comb_resp_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_vec;
    logic [3:0]  in_y;
    logic        busy, done, pass, err_seen;
    logic [4:0]  vec_cnt, err_cnt;
    logic [3:0]  first_err_vec;
    logic [15:0] signature;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_sig;

    comb_resp_checker #(.WIDTH(4), .NVEC(16), .SIG_SEED(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_vec(in_vec), .in_y(in_y), .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_vec(first_err_vec),
        .err_seen(err_seen), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference MISR model, written from the algorithm description.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [3:0] y);
        logic [15:0] r;
        r = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, y};
        return r;
    endfunction

    function automatic logic [15:0] exp_sig();
`ifdef COMB_CHK_MISR_EN
        return model_sig;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic with_sample);
        start    = 1'b1;
        in_valid = with_sample;
        in_vec   = 4'h3;
        in_y     = 4'h5;
        cyc();
        start     = 1'b0;
        in_valid  = 1'b0;
        model_sig = 16'hFFFF;
    endtask

    // Sends one sample while running. The model advances only for accepted samples.
    task automatic send(input logic [3:0] v, input logic [3:0] y, input logic counts);
        in_valid = 1'b1;
        in_vec   = v;
        in_y     = y;
        cyc();
        in_valid = 1'b0;
        if (counts) model_sig = ref_step(model_sig, y);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass"}, pass, 1'b0);
        chk({tag, "_vec"}, vec_cnt, 5'd0);
        chk({tag, "_err"}, err_cnt, 5'd0);
        chk({tag, "_first"}, first_err_vec, 4'd0);
        chk({tag, "_seen"}, err_seen, 1'b0);
        chk({tag, "_sig"}, signature, exp_sig());
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = 4'h0; in_y = 4'h0;
        model_sig = 16'hFFFF;

        // Reset held for 3 cycles, then in_valid without start
        repeat (3) cyc();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        in_valid = 1'b1; in_y = 4'hF;
        repeat (5) cyc();
        in_valid = 1'b0;
        chk("idle_vec", vec_cnt, 5'd0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_sig", signature, exp_sig());

        // Clean run. The sample on the start edge is discarded.
        do_start(1'b1);
        chk("start_busy", busy, 1'b1);
        chk("start_discard", vec_cnt, 5'd0);
        for (int i = 0; i < 16; i++) begin
            send(4'(i), (i % 2 == 1) ? 4'hF : 4'h0, 1'b1);
            if (i == 14) chk("clean_done_early", done, 1'b0);
        end
        chk("clean_done", done, 1'b1);
        chk("clean_busy", busy, 1'b0);
        chk("clean_vec", vec_cnt, 5'd16);
        chk("clean_err", err_cnt, 5'd0);
        chk("clean_pass", pass, 1'b1);
        chk("clean_sig", signature, exp_sig());

        // Single MISR steps, checked against hand-computed constants
        do_start(1'b0);
        send(4'h0, 4'h0, 1'b1);
`ifdef COMB_CHK_MISR_EN
        chk("misr_y0", signature, 16'hEFDF);
`else
        chk("misr_y0", signature, 16'h0000);
`endif
        do_start(1'b0);
        send(4'h0, 4'hF, 1'b1);
`ifdef COMB_CHK_MISR_EN
        chk("misr_yF", signature, 16'hEFD0);
`else
        chk("misr_yF", signature, 16'h0000);
`endif

        // Mismatch logging
        do_start(1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] y;
            y = (i % 2 == 1) ? 4'hF : 4'h0;
            if (i == 5) y = 4'b0111;
            if (i == 9) y = 4'b1000;
            send(4'(i), y, 1'b1);
            if (i == 4) chk("mm_seen_before", err_seen, 1'b0);
            if (i == 5) chk("mm_first_at5", first_err_vec, 4'd5);
        end
        chk("mm_err", err_cnt, 5'd2);
        chk("mm_first", first_err_vec, 4'd5);
        chk("mm_seen", err_seen, 1'b1);
        chk("mm_done", done, 1'b1);
        chk("mm_pass", pass, 1'b0);
        chk("mm_sig", signature, exp_sig());

        // Extra samples in DONE are ignored
        for (int i = 0; i < 3; i++) send(4'hA, 4'h3, 1'b0);
        chk("ovf_vec", vec_cnt, 5'd16);
        chk("ovf_err", err_cnt, 5'd2);
        chk("ovf_done", done, 1'b1);
        chk("ovf_sig", signature, exp_sig());

        // Restart mid-run after sample 7
        do_start(1'b0);
        for (int i = 0; i < 7; i++) send(4'(i + 1), 4'h6, 1'b1);
        chk("pre_rs_err", err_cnt, 5'd7);
        do_start(1'b1);
        chk("rs_vec", vec_cnt, 5'd0);
        chk("rs_err", err_cnt, 5'd0);
        chk("rs_seen", err_seen, 1'b0);
        chk("rs_first", first_err_vec, 4'd0);
        chk("rs_sig", signature, exp_sig());
        chk("rs_busy", busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(4'(15 - i), 4'hF, 1'b1);
            if (i == 14) chk("rs_done_early", done, 1'b0);
        end
        chk("rs_done", done, 1'b1);
        chk("rs_vec16", vec_cnt, 5'd16);
        chk("rs_pass", pass, 1'b1);

        // Async reset between edges after sample 3
        do_start(1'b0);
        for (int i = 0; i < 3; i++) send(4'(i), 4'b0011, 1'b1);
        chk("ar_vec3", vec_cnt, 5'd3);
        #2;
        rst_n = 1'b0;
        model_sig = 16'hFFFF;
        #1;
        chk_reset_vals("ar");
        #3;
        rst_n = 1'b1;
        in_valid = 1'b1; in_y = 4'h1;
        repeat (2) cyc();
        in_valid = 1'b0;
        chk("ar_idle_busy", busy, 1'b0);
        chk("ar_idle_vec", vec_cnt, 5'd0);
        chk("ar_idle_sig", signature, exp_sig());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
